serial_sub_4bit: RTL and testbench
==================================

SERIAL_SUB_4BIT -- requirements
Module: serial_sub_4bit

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning the operand/result width in bits (legal range 2..16).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  operands a, b and bin are valid.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have ports a and b  input  WIDTH  minuend and subtrahend, unsigned.
REQ-007 SHALL have port bin  input  1  borrow-in.
REQ-008 SHALL have port out_valid  output  1  diff and bout are valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-010 SHALL have port diff  output  WIDTH  the result a - b - bin, modulo 2^WIDTH.
REQ-011 SHALL have port bout  output  1  borrow-out, 1 when a < b + bin.

Function
REQ-012 SHALL implement an FSM with states IDLE, CALC and DONE.
REQ-013 SHALL assert in_ready only in IDLE, and out_valid only in DONE.
REQ-014 SHALL accept operands on a rising edge where in_valid && in_ready: latch a, b and bin, clear the bit counter, and go to CALC.
REQ-015 SHALL process one bit per CALC cycle, LSB first, through the full-subtractor sub-module:
- borrow register initialised from bin;
- diff bit shifted into the result register;
- counter incremented.
REQ-016 SHALL go from CALC to DONE on the edge that processes bit WIDTH-1, so out_valid rises exactly WIDTH cycles after the accept edge.
REQ-017 SHALL hold diff, bout and out_valid stable in DONE until out_valid && out_ready.
REQ-018 SHALL return to IDLE on the out_valid && out_ready edge, so in_ready is 1 in the following cycle (no accept in the same cycle as result handoff).
REQ-019 SHALL ignore in_valid outside IDLE, and ignore out_ready outside DONE.
REQ-020 SHALL wrap diff modulo 2^WIDTH with no saturation, e.g. 0 - 0 - 1 gives all-ones with bout=1.
REQ-021 SHALL keep diff and bout at their last values while in IDLE and CALC; the only change is the internal shift register.

Reset
REQ-022 SHALL, on rst=1 at a clock edge, force state=IDLE, counter=0, diff=0, bout=0, out_valid=0 and in_ready=1 on the following cycle.
REQ-023 SHALL abort any CALC or DONE operation on reset mid-operation, with no result emitted.
REQ-024 SHALL give rst priority over every handshake in the same cycle.

Configuration
REQ-025 SHALL, when SERIAL_SUB_OVF_EN is defined, add output ovf (1 bit), valid with out_valid, equal to two's-complement signed overflow of a - b - bin (operand signs differ and diff sign differs from a); ovf resets to 0.
REQ-026 SHALL, when SERIAL_SUB_OVF_EN is undefined, have no ovf port and no related logic.

Structure
REQ-027 SHALL take the FSM state encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2) and the default width constant from shared package adld_arith_pkg.
REQ-028 SHALL place the single-bit subtraction in sub-module full_sub (d = x^y^bi; bo = ~x&y | ~(x^y)&bi), instantiated once.

Verification
REQ-029 SHALL be verified with these scenarios:
- a=9, b=8, bin=0 -> diff=1, bout=0; out_valid exactly 4 cycles after the accept edge.
- a=8, b=9, bin=0 -> diff=15, bout=1.
- a=8, b=7, bin=1 -> diff=0, bout=0.
- out_ready held 0 for 5 cycles after out_valid -> diff and bout stable, in_ready=0 throughout, new in_valid ignored; result released on the out_ready edge, in_ready=1 the next cycle.
- rst pulsed 2 cycles after accept -> out_valid never rises, in_ready=1 after reset; next op 0-0 with bin=1 -> diff=15, bout=1.
- With SERIAL_SUB_OVF_EN: a=8, b=1, bin=0 -> diff=7, ovf=1; a=3, b=1 -> diff=2, ovf=0.

Source files
------------

// File: rtl/adld_arith_pkg.sv
// adld_arith_pkg
//   Shared constants and types for the arithmetic blocks.
//   SUB_WIDTH_DEFAULT : default operand/result width of the serial subtractor
//   sub_state_e       : serial subtractor FSM state encoding
package adld_arith_pkg;

    localparam int unsigned SUB_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } sub_state_e;

endpackage : adld_arith_pkg

// File: rtl/serial_sub_4bit_full_sub.sv
// full_sub
//   Single-bit full subtractor: x - y - bi.
//   x_i  : minuend bit
//   y_i  : subtrahend bit
//   bi_i : borrow in
//   d_o  : difference bit
//   bo_o : borrow out
module full_sub (
    input  logic x_i,
    input  logic y_i,
    input  logic bi_i,
    output logic d_o,
    output logic bo_o
);

    assign d_o  = x_i ^ y_i ^ bi_i;
    assign bo_o = (~x_i & y_i) | (~(x_i ^ y_i) & bi_i);

endmodule : full_sub

// File: rtl/serial_sub_4bit.sv
// serial_sub_4bit
//   Bit-serial unsigned subtractor, diff = a - b - bin mod 2^WIDTH, one bit
//   per clock LSB first, with valid/ready handshakes on both sides.
//   Optional feature macro: SERIAL_SUB_OVF_EN adds the signed-overflow output ovf.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   in_valid  : a, b, bin valid          in_ready  : accepting operands (IDLE)
//   a, b      : minuend / subtrahend     bin       : borrow in
//   out_valid : diff/bout valid (DONE)   out_ready : consumer takes result
//   diff      : result                   bout      : borrow out (a < b + bin)
//   ovf       : two's-complement overflow (only with SERIAL_SUB_OVF_EN)
module serial_sub_4bit
    import adld_arith_pkg::*;
#(
    parameter int unsigned WIDTH = SUB_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    sub_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // Minuend shifts out at the LSB while difference bits enter at the MSB,
    // so after WIDTH steps this register holds the complete result.
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             ovf_q, ovf_d;
`endif

    logic             fs_d, fs_bo;

    full_sub u_full_sub (
        .x_i  (sh_q[0]),
        .y_i  (b_q[0]),
        .bi_i (borrow_q),
        .d_o  (fs_d),
        .bo_o (fs_bo)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d  = CALC;
                    cnt_d    = '0;
                    sh_d     = a;
                    b_d      = b;
                    borrow_d = bin;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb_d  = a[WIDTH-1];
                    b_msb_d  = b[WIDTH-1];
`endif
                end
            end
            CALC: begin
                sh_d     = {fs_d, sh_q[WIDTH-1:1]};
                b_d      = {1'b0, b_q[WIDTH-1:1]};
                borrow_d = fs_bo;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                    diff_d  = {fs_d, sh_q[WIDTH-1:1]};
                    bout_d  = fs_bo;
`ifdef SERIAL_SUB_OVF_EN
                    // fs_d is the result MSB on the final step.
                    ovf_d   = (a_msb_q != b_msb_q) && (fs_d != a_msb_q);
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sh_q     <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule : serial_sub_4bit

// File: tb/tb_serial_sub_4bit.sv
module tb_serial_sub_4bit;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    serial_sub_4bit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Full transaction: present operands, wait for the result (bounded),
    // check latency and values, then hand the result off.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                          input logic [W-1:0] ed, input logic eb, input logic early,
                          input string tag);
        int unsigned lat;
        a = ta; b = tb_v; bin = tbin; in_valid = 1'b1; out_ready = early;
        chk({tag, ":in_ready_before"}, 16'(in_ready), 16'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; a = ~ta; b = ~tb_v; bin = ~tbin;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ":latency"}, 16'(lat), 16'd4);
        chk({tag, ":diff"}, 16'(diff), 16'(ed));
        chk({tag, ":bout"}, 16'(bout), 16'(eb));
        chk({tag, ":in_ready_done"}, 16'(in_ready), 16'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ":out_valid_after"}, 16'(out_valid), 16'd0);
        chk({tag, ":in_ready_after"}, 16'(in_ready), 16'd1);
        chk({tag, ":diff_hold_idle"}, 16'(diff), 16'(ed));
    endtask

`ifdef SERIAL_SUB_OVF_EN
    task automatic run_ovf(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                           input logic [W-1:0] ed, input logic eo, input string tag);
        int unsigned lat;
        a = ta; b = tb_v; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ":diff"}, 16'(diff), 16'(ed));
        chk({tag, ":ovf"}, 16'(ovf), 16'(eo));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset:in_ready", 16'(in_ready), 16'd1);
        chk("reset:out_valid", 16'(out_valid), 16'd0);
        chk("reset:diff", 16'(diff), 16'd0);
        chk("reset:bout", 16'(bout), 16'd0);

        run_op(4'd9, 4'd8, 1'b0, 4'd1,  1'b0, 1'b0, "9-8");
        run_op(4'd8, 4'd9, 1'b0, 4'd15, 1'b1, 1'b0, "8-9");
        run_op(4'd8, 4'd7, 1'b1, 4'd0,  1'b0, 1'b1, "8-7-1_early_ready");
        run_op(4'd0, 4'd15, 1'b0, 4'd1, 1'b1, 1'b0, "0-15");
        run_op(4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0, "15-15-1");

        // Backpressure: 5 - 3 = 2, consumer stalls five cycles.
        a = 4'd5; b = 4'd3; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("stall:out_valid_rise", 16'(out_valid), 16'd1);
        a = 4'd15; b = 4'd0; bin = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("stall:diff", 16'(diff), 16'd2);
            chk("stall:bout", 16'(bout), 16'd0);
            chk("stall:in_ready", 16'(in_ready), 16'd0);
            chk("stall:out_valid", 16'(out_valid), 16'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("stall:in_ready_after_handoff", 16'(in_ready), 16'd1);
        chk("stall:out_valid_after_handoff", 16'(out_valid), 16'd0);
        in_valid = 1'b0;
        chk("stall:diff_after_handoff", 16'(diff), 16'd2);

        // Reset two cycles after accept aborts the operation.
        a = 4'd9; b = 4'd8; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("abort:diff_hold_calc", 16'(diff), 16'd2);
        @(posedge clk); #1;
        chk("abort:out_valid_pre", 16'(out_valid), 16'd0);
        rst = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b0;
        chk("abort:in_ready", 16'(in_ready), 16'd1);
        chk("abort:diff", 16'(diff), 16'd0);
        chk("abort:bout", 16'(bout), 16'd0);
        for (int i = 0; i < 8; i++) begin
            chk("abort:out_valid_quiet", 16'(out_valid), 16'd0);
            @(posedge clk); #1;
        end
        run_op(4'd0, 4'd0, 1'b1, 4'd15, 1'b1, 1'b0, "0-0-1");

`ifdef SERIAL_SUB_OVF_EN
        run_ovf(4'd8, 4'd1, 4'd7, 1'b1, "ovf:8-1");
        run_ovf(4'd3, 4'd1, 4'd2, 1'b0, "ovf:3-1");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_serial_sub_4bit
